stoch_bitstream_decoder: RTL



---
 rtl/stoch_bitstream_decoder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/stoch_bitstream_decoder.sv
// Stochastic bitstream decoder: counts ones over a BITSTREAM-bit frame received as LANES-bit beats
// and scales the count to QUANT bits. Define SDEC_BIPOLAR_EN for bipolar two's-complement output.
module stoch_bitstream_decoder #(
    parameter int BITSTREAM = 64,
    parameter int QUANT     = 8,
    parameter int LANES     = 8
) (
    input  logic                       iClk,
    input  logic                       iRst,
    input  logic                       iValid,
    output logic                       oReady,
    input  logic [LANES-1:0]           iBits,
    output logic                       oValid,
    input  logic                       iReady,
    output logic [QUANT-1:0]           oData,
    output logic [$clog2(BITSTREAM):0] oCount
);

    localparam int LOG2B = $clog2(BITSTREAM);
    localparam int CW    = LOG2B + 1;
    localparam int BEATS = BITSTREAM / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PW    = $clog2(LANES) + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_acc;
    logic [BW-1:0]   r_beat;
    logic [QUANT-1:0] r_data;
    logic [CW-1:0]   r_count;

    logic            w_accept;
    logic            w_last;
    logic [PW-1:0]   w_pop;
    logic [CW-1:0]   w_sum;
    logic [QUANT-1:0] w_scaled;

    function automatic logic [PW-1:0] popcount(input logic [LANES-1:0] bits);
        logic [PW-1:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++) begin
            n = n + PW'(bits[i]);
        end
        return n;
    endfunction

`ifdef SDEC_BIPOLAR_EN
    localparam int SW = QUANT + LOG2B + 2;

    // s = 2*count - BITSTREAM, rescaled to QUANT-bit signed; only count == BITSTREAM overflows.
    function automatic logic [QUANT-1:0] scale_bipolar(input logic [CW-1:0] count);
        logic signed [SW-1:0] one;
        logic signed [SW-1:0] s;
        logic signed [SW-1:0] t;
        logic signed [SW-1:0] hi;
        logic signed [SW-1:0] lo;
        one = SW'(1);
        s   = $signed(SW'(count) << 1) - $signed(SW'(BITSTREAM));
        t   = (s <<< (QUANT - 1)) >>> LOG2B;
        hi  = (one <<< (QUANT - 1)) - one;
        lo  = -(one <<< (QUANT - 1));
        if (t > hi) begin
            t = hi;
        end else if (t < lo) begin
            t = lo;
        end
        return t[QUANT-1:0];
    endfunction
`else
    localparam int TW = QUANT + LOG2B + 1;

    // Truncating rescale; a full-ones frame lands exactly on 2^QUANT and saturates.
    function automatic logic [QUANT-1:0] scale_unipolar(input logic [CW-1:0] count);
        logic [TW-1:0] t;
        t = (TW'(count) << QUANT) >> LOG2B;
        if (|t[TW-1:QUANT]) begin
            return '1;
        end
        return t[QUANT-1:0];
    endfunction
`endif

    assign w_pop  = popcount(iBits);
    assign w_sum  = r_acc + CW'(w_pop);
    assign w_last = (r_beat == LAST_BEAT);

`ifdef SDEC_BIPOLAR_EN
    assign w_scaled = scale_bipolar(w_sum);
`else
    assign w_scaled = scale_unipolar(w_sum);
`endif

    // oReady is gated by iRst so upstream never sees a handshake while reset is held.
    always_comb begin
        w_state_nxt = r_state;
        oReady      = 1'b0;
        oValid      = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ACCUM: begin
                oReady   = ~iRst;
                w_accept = iValid & ~iRst;
                if (w_accept && w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                oValid = 1'b1;
                if (iReady) begin
                    w_state_nxt = ACCUM;
                end
            end
            default: w_state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state <= ACCUM;
            r_acc   <= '0;
            r_beat  <= '0;
            r_data  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                if (w_last) begin
                    r_acc   <= '0;
                    r_beat  <= '0;
                    r_count <= w_sum;
                    r_data  <= w_scaled;
                end else begin
                    r_acc  <= w_sum;
                    r_beat <= r_beat + 1'b1;
                end
            end
        end
    end

    assign oData  = r_data;
    assign oCount = r_count;

endmodule
